// File: rtl/p_s_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : p_s_converter_if
//  Description : Load handshake and serial output bundle for p_s_converter.
//                master = word source / line observer, slave = converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface p_s_converter_if #(
    parameter int C_BITS_IN = 8
);
    logic [C_BITS_IN-1:0] D;
    logic                 LOAD_VALID;
    logic                 LOAD_READY;
    logic                 Q;
    logic                 Q_VALID;
    logic                 FRAME;
    logic                 UNDERRUN;

    modport master (
        output D, LOAD_VALID,
        input  LOAD_READY, Q, Q_VALID, FRAME, UNDERRUN
    );

    modport slave (
        input  D, LOAD_VALID,
        output LOAD_READY, Q, Q_VALID, FRAME, UNDERRUN
    );
endinterface
`default_nettype wire

// File: rtl/p_s_converter.sv
`default_nettype none
// ============================================================================
//  Module      : p_s_converter
//  Description : Parallel-to-serial transmitter. One-word holding buffer fed
//                by a valid/ready handshake; at every frame boundary the
//                buffered word is shifted out MSB first, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module p_s_converter #(
    parameter int C_BITS_IN      = 8,
    parameter int C_FRAME_CYCLES = 250
) (
    input  wire logic            CK,
    input  wire logic            RST,
    p_s_converter_if.slave       bus
);

    localparam int FC_W  = (C_FRAME_CYCLES > 1) ? $clog2(C_FRAME_CYCLES) : 1;
    localparam int CNT_W = (C_BITS_IN > 1) ? $clog2(C_BITS_IN) : 1;

    localparam logic [FC_W-1:0]  c_FC_LAST  = FC_W'(C_FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(C_BITS_IN - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [FC_W-1:0]      r_fc;
    logic [C_BITS_IN-1:0] r_hold;
    logic                 r_full;
    logic [C_BITS_IN-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic [0:0]           r_state;
    logic                 r_q;
    logic                 r_q_valid;
    logic                 r_frame;
    logic                 r_underrun;

    logic w_boundary;
    logic w_accept;
    logic w_slot;
    logic w_xfer;

    assign w_boundary = (r_fc == c_FC_LAST);
    // Full flag alone gates acceptance, so a boundary edge that empties the
    // buffer can never also accept into it.
    assign w_accept   = bus.LOAD_VALID && !r_full;
    // A boundary may start a word only when no word is in flight, or on the
    // final bit (gapless case when frame length equals word length).
    assign w_slot     = (r_state == c_IDLE) || (r_cnt == '0);
    assign w_xfer     = w_boundary && w_slot && r_full;

    // Free-running frame counter, wraps at the frame period.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_fc <= '0;
        end else if (w_boundary) begin
            r_fc <= '0;
        end else begin
            r_fc <= r_fc + FC_W'(1);
        end
    end

    // Holding register: emptied by a frame transfer, filled by an accept.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_hold <= bus.D;
            r_full <= 1'b1;
        end else if (w_xfer) begin
            r_full <= 1'b0;
        end
    end

    // Shift state machine with registered serial outputs.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_state    <= c_IDLE;
            r_q        <= 1'b0;
            r_q_valid  <= 1'b0;
            r_frame    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_frame    <= 1'b0;
            r_underrun <= 1'b0;
            if (w_boundary && w_slot) begin
                if (r_full) begin
                    r_shift   <= r_hold;
                    r_cnt     <= c_CNT_LAST;
                    r_state   <= c_SHIFT;
                    r_q       <= r_hold[C_BITS_IN-1];
                    r_q_valid <= 1'b1;
                    r_frame   <= 1'b1;
                end else begin
                    r_state    <= c_IDLE;
                    r_q        <= 1'b0;
                    r_q_valid  <= 1'b0;
                    r_underrun <= 1'b1;
                end
            end else if (r_state == c_SHIFT) begin
                if (r_cnt == '0) begin
                    r_state   <= c_IDLE;
                    r_q       <= 1'b0;
                    r_q_valid <= 1'b0;
                end else begin
                    r_shift   <= {r_shift[C_BITS_IN-2:0], 1'b0};
                    r_cnt     <= r_cnt - CNT_W'(1);
                    r_q       <= r_shift[C_BITS_IN-2];
                    r_q_valid <= 1'b1;
                end
            end else begin
                r_q       <= 1'b0;
                r_q_valid <= 1'b0;
            end
        end
    end

    assign bus.LOAD_READY = ~r_full;
    assign bus.Q          = r_q;
    assign bus.Q_VALID    = r_q_valid;
    assign bus.FRAME      = r_frame;
    assign bus.UNDERRUN   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_p_s_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_p_s_converter
//  Description : Scoreboard bench for p_s_converter. Two instances: frame 12
//                and frame 8 (gapless), both with 8-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_p_s_converter;

    localparam int B  = 8;
    localparam int F0 = 12;
    localparam int F1 = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    p_s_converter_if #(.C_BITS_IN(B)) bus0 ();
    p_s_converter_if #(.C_BITS_IN(B)) bus1 ();

    p_s_converter #(.C_BITS_IN(B), .C_FRAME_CYCLES(F0)) dut0 (.CK(clk), .RST(rst), .bus(bus0));
    p_s_converter #(.C_BITS_IN(B), .C_FRAME_CYCLES(F1)) dut1 (.CK(clk), .RST(rst), .bus(bus1));

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;

    // Reference model: one buffered word per unit; each frame boundary turns
    // a buffered word into B expected (bit, frame-flag, due-cycle) entries.
    logic         m_full  [2];
    logic [B-1:0] m_hold  [2];
    logic         m_und   [2];
    int           acc_cnt [2];
    logic         eb [2][0:255];
    logic         ef [2][0:255];
    int           ed [2][0:255];
    int           head [2];
    int           tail [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int u = 0; u < 2; u++) begin
            m_full[u] = 1'b0;
            m_und[u]  = 1'b0;
            head[u]   = 0;
            tail[u]   = 0;
        end
    endtask

    task automatic model_step(input int u, input int fper, input logic v, input logic [B-1:0] d);
        logic bnd;
        logic fo;
        bnd = ((ecount % fper) == 0);
        fo  = m_full[u];
        m_und[u] = bnd && !fo;
        if (bnd && fo) begin
            for (int k = 0; k < B; k++) begin
                eb[u][tail[u] % 256] = m_hold[u][B-1-k];
                ef[u][tail[u] % 256] = (k == 0);
                ed[u][tail[u] % 256] = ecount + k;
                tail[u]++;
            end
            m_full[u] = 1'b0;
        end
        if (v && !fo) begin
            m_hold[u] = d;
            m_full[u] = 1'b1;
            acc_cnt[u]++;
        end
    endtask

    task automatic mon(input int u, input logic q, input logic qv, input logic fr,
                       input logic und, input logic rdy);
        int idx;
        check($sformatf("u%0d load_ready", u), {31'd0, rdy}, {31'd0, !m_full[u]});
        check($sformatf("u%0d underrun", u), {31'd0, und}, {31'd0, m_und[u]});
        if (qv) begin
            if (head[u] == tail[u]) begin
                check($sformatf("u%0d spurious q_valid", u), 32'd1, 32'd0);
            end else begin
                idx = head[u] % 256;
                check($sformatf("u%0d q bit", u), {31'd0, q}, {31'd0, eb[u][idx]});
                check($sformatf("u%0d frame", u), {31'd0, fr}, {31'd0, ef[u][idx]});
                check($sformatf("u%0d bit cycle", u), ecount, ed[u][idx]);
                head[u]++;
            end
        end else begin
            check($sformatf("u%0d idle q", u), {31'd0, q}, 32'd0);
            check($sformatf("u%0d idle frame", u), {31'd0, fr}, 32'd0);
            if (head[u] != tail[u] && ed[u][head[u] % 256] <= ecount) begin
                check($sformatf("u%0d missing bit", u), 32'd0, 32'd1);
                head[u]++;
            end
        end
    endtask

    // Model advances on every active edge using the inputs the DUT sampled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ecount = 0;
            model_clear();
        end else begin
            ecount++;
            model_step(0, F0, bus0.LOAD_VALID, bus0.D);
            model_step(1, F1, bus1.LOAD_VALID, bus1.D);
        end
    end

    // Monitor samples outputs on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus0.Q, bus0.Q_VALID, bus0.FRAME, bus0.UNDERRUN, bus0.LOAD_READY);
            mon(1, bus1.Q, bus1.Q_VALID, bus1.FRAME, bus1.UNDERRUN, bus1.LOAD_READY);
        end
    end

    // Wait (bounded) until the next edge of unit 0 lands on frame phase r.
    task automatic wait_phase(input int r);
        int n;
        n = 0;
        while (((ecount + 1) % F0) != r && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("wait_phase timeout", 32'd0, 32'd1);
    endtask

    task automatic load0(input logic [B-1:0] d);
        bus0.LOAD_VALID = 1'b1;
        bus0.D          = d;
        @(negedge clk);
        bus0.LOAD_VALID = 1'b0;
    endtask

    task automatic wait_acc(input int u, input int target);
        int n;
        n = 0;
        while (acc_cnt[u] < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check($sformatf("u%0d accept timeout", u), 32'd0, 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " q"},        {31'd0, bus0.Q},          32'd0);
        check({tag, " q_valid"},  {31'd0, bus0.Q_VALID},    32'd0);
        check({tag, " frame"},    {31'd0, bus0.FRAME},      32'd0);
        check({tag, " ready"},    {31'd0, bus0.LOAD_READY}, 32'd1);
    endtask

    initial begin
        int base;
        int n;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        model_clear();
        bus0.LOAD_VALID = 1'b0;
        bus0.D          = '0;
        bus1.LOAD_VALID = 1'b0;
        bus1.D          = '0;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        check("reset underrun", {31'd0, bus0.UNDERRUN}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: underruns at edges 12, 24, 36
        repeat (40) @(negedge clk);

        // Single word
        wait_phase(3);
        load0(8'hA5);
        repeat (30) @(negedge clk);

        // Backpressure: FF held while buffer is full
        wait_phase(3);
        base = acc_cnt[0];
        load0(8'h3C);
        bus0.LOAD_VALID = 1'b1;
        bus0.D          = 8'hFF;
        wait_acc(0, base + 2);
        bus0.LOAD_VALID = 1'b0;
        repeat (30) @(negedge clk);

        // Load exactly on the boundary edge with an empty buffer
        wait_phase(0);
        load0(8'h5A);
        repeat (30) @(negedge clk);

        // Back-to-back on the frame-8 unit
        base = acc_cnt[1];
        bus1.LOAD_VALID = 1'b1;
        bus1.D          = 8'h81;
        wait_acc(1, base + 1);
        bus1.D          = 8'h7E;
        wait_acc(1, base + 2);
        bus1.LOAD_VALID = 1'b0;
        repeat (30) @(negedge clk);

        // Async reset during the 4th bit of F0
        wait_phase(3);
        load0(8'hF0);
        n = 0;
        while (!bus0.FRAME && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("frame wait timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("pre-reset 4th bit", {31'd0, bus0.Q}, 32'd1);
        #1 rst = 1'b1;
        #1 check_quiet("async reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized traffic on both units
        repeat (800) begin
            @(negedge clk);
            bus0.LOAD_VALID = ($urandom_range(0, 3) == 0);
            bus0.D          = B'($urandom);
            bus1.LOAD_VALID = ($urandom_range(0, 1) == 0);
            bus1.D          = B'($urandom);
        end
        bus0.LOAD_VALID = 1'b0;
        bus1.LOAD_VALID = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/p_s_converter.md
Name: p_s_converter

Overview:
Parallel-to-serial converter, the transmit counterpart of the s_p_converter receiver. Accepts a C_BITS_IN-wide word over a valid/ready handshake and buffers it in a one-word holding register. At each frame boundary it shifts the word out MSB first, one bit per CK, so a matching receiver with the same frame period latches the word intact (first bit sent lands in receiver Q[C_BITS_IN-1]). Between frames and on underrun, the serial line idles at 0.

Parameters:
C_BITS_IN, 8, parallel word width; must be >= 2.
C_FRAME_CYCLES, 250, frame period in CK cycles; must be >= C_BITS_IN.

Ports:
CK  input  1  clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
D  input  C_BITS_IN  parallel word to transmit.
LOAD_VALID  input  1  D is valid this cycle.
LOAD_READY  output  1  holding register is empty; the word is accepted on an edge where LOAD_VALID && LOAD_READY.
Q  output  1  serial data, registered.
Q_VALID  output  1  high while Q carries a payload bit, registered.
FRAME  output  1  high only during the first (MSB) bit of a frame, registered.
UNDERRUN  output  1  one-cycle pulse when a frame boundary finds the holding register empty, registered.

Behaviour:
- Reset (async, immediate): fc=0, holding register empty, shift register=0, bit counter=0, state IDLE, Q=0, Q_VALID=0, FRAME=0, UNDERRUN=0. LOAD_READY=1 during and after reset.
- Reset asserted mid-word aborts the word with no completion. A buffered word is discarded.
- Frame counter fc, width $clog2(C_FRAME_CYCLES):
  - Free-running 0..C_FRAME_CYCLES-1, then wraps to 0.
  - A frame boundary is the edge where fc goes C_FRAME_CYCLES-1 -> 0.
  - The first boundary is the C_FRAME_CYCLES-th edge after RST deasserts.
- LOAD_READY is the inverse of the holding-register full flag (a register output, no combinational path from LOAD_VALID).
- Accept rule:
  - On an accepting edge, the holding register captures D and full is set.
  - LOAD_VALID while full is ignored; D need not be held stable by the sender.
- Word-accept and frame-boundary transfer never coincide on one holding register state:
  - A word accepted on the boundary edge itself is not sent in that frame.
  - That word waits for the next boundary.
- State IDLE:
  - Q=0, Q_VALID=0, FRAME=0.
  - At a boundary edge with holding full: shift register <= holding, holding empty, bit counter <= C_BITS_IN-1, go to SHIFT.
  - Q becomes shift register MSB; Q_VALID=1 and FRAME=1 for that cycle.
  - At a boundary edge with holding empty: stay IDLE, UNDERRUN=1 for one cycle.
- State SHIFT:
  - Each edge shifts left by one (zero fill) and decrements the bit counter; FRAME=0.
  - Q always shows the current MSB.
  - When the bit counter is 0 on an edge, the word ends: go to IDLE, Q=0, Q_VALID=0.
  - Q_VALID is high for exactly C_BITS_IN cycles per frame.
- Boundary coincident with the last bit (only possible when C_FRAME_CYCLES == C_BITS_IN):
  - The boundary wins: reload from holding if full, giving a gapless next frame with Q_VALID staying 1.
  - Otherwise go to IDLE with UNDERRUN pulsed.
- Holding register refill during SHIFT is allowed (double buffering), so LOAD_READY can reassert the cycle after a transfer.
- Latency: a word accepted at least one cycle before a boundary appears on Q starting the cycle after that boundary edge. Its MSB is on Q for one cycle, its LSB C_BITS_IN-1 cycles later.

Test Plan:
- Reset/idle: C_BITS_IN=8, C_FRAME_CYCLES=12, RST pulse, no loads -> Q=0, Q_VALID=0, LOAD_READY=1. UNDERRUN pulses on edges 12, 24, 36 after release.
- Single word: load D=8'hA5 at cycle 3 -> LOAD_READY drops at the next cycle. After edge 12: Q sequence 1,0,1,0,0,1,0,1 with Q_VALID=1 for 8 cycles, FRAME=1 on the first only, then Q=0. LOAD_READY returns to 1 after edge 12.
- Backpressure: load 8'h3C, then hold LOAD_VALID=1 with D=8'hFF while full -> 8'hFF is ignored until the transfer. 8'hFF is accepted the cycle after the boundary and sent in the next frame: 00111100 then 11111111.
- Boundary-edge load: assert load exactly on the boundary edge with holding empty -> UNDERRUN=1 for that frame. The word is sent at the following boundary, 12 cycles later.
- Back-to-back: C_FRAME_CYCLES=C_BITS_IN=8, keep holding full with 8'h81, 8'h7E -> 16 consecutive Q_VALID=1 cycles, bits 10000001 01111110, FRAME at bit 0 and bit 8.
- Async reset mid-word: assert RST during the 4th bit of 8'hF0 -> Q, Q_VALID and FRAME drop immediately without waiting for CK, and LOAD_READY=1. After release, the next boundary is 12 edges later with UNDERRUN=1.
